// File: rtl/layer_sequencer_pkg.sv
// Shared types and sizing helpers for the layer sequencer and its buffers.
// DATA_W/OUT_W defaults track the network-wide dataWidth and ROM_bitwidth.
package layer_sequencer_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int OUT_W_DEF  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BCAST,
      S_WAIT,
      S_DRAIN
   } state_e;

   // Counter width able to hold the value 'range' itself
   function automatic int cnt_w(input int range);
      return $clog2(range) + 1;
   endfunction

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/layer_sequencer_seq_buf.sv
// Register-array buffer with one addressed write port, optional per-entry
// parallel writes and a write-first registered read port.
module seq_buf
   import layer_sequencer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   parameter int AW    = addr_w(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en_i,
   input  logic [AW-1:0]          wr_addr_i,
   input  logic [WIDTH-1:0]       wr_data_i,
   input  logic [DEPTH-1:0]       par_we_i,
   input  logic [DEPTH*WIDTH-1:0] par_data_i,
   input  logic                   rd_en_i,
   input  logic [AW-1:0]          rd_addr_i,
   output logic [WIDTH-1:0]       rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] rd_word;

   // NOTE: the storage array is deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (par_we_i[i])
            mem_q[i] <= par_data_i[i*WIDTH +: WIDTH];
         else if (wr_en_i && wr_addr_i == AW'(i))
            mem_q[i] <= wr_data_i;
      end
   end

   // Forward same-cycle writes so a read issued with the final write sees it.
   // NOTE: rd_word gets a default first so this block can never infer a latch.
   always_comb begin
      rd_word = '0;
      if (int'(rd_addr_i) < DEPTH)
         rd_word = mem_q[rd_addr_i];
      if (wr_en_i && wr_addr_i == rd_addr_i)
         rd_word = wr_data_i;
      for (int i = 0; i < DEPTH; i++)
         if (par_we_i[i] && rd_addr_i == AW'(i))
            rd_word = par_data_i[i*WIDTH +: WIDTH];
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data_q <= '0;
      else if (rd_en_i)
         rd_data_q <= rd_word;
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/layer_sequencer.sv
// Loads an input vector, broadcasts it as one gapless burst to all neurons,
// collects each neuron's activation and drains the results downstream.
module layer_sequencer
   import layer_sequencer_pkg::*;
#(
   parameter int NUM_IN     = 128,
   parameter int NUM_NEURON = 32,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int TIMEOUT    = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       nrn_in_valid,
   output logic [DATA_W-1:0]          nrn_in_data,
   input  logic [NUM_NEURON-1:0]      nrn_out_valid,
   input  logic [NUM_NEURON*OUT_W-1:0] nrn_out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic                       busy,
   output logic                       err
);

   localparam int IN_AW  = addr_w(NUM_IN);
   localparam int NN_AW  = addr_w(NUM_NEURON);
   localparam int WCNT_W = cnt_w(NUM_IN);
   localparam int DCNT_W = cnt_w(NUM_NEURON);
   localparam int TCNT_W = cnt_w(TIMEOUT);

   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NUM_IN - 1);
   localparam logic [WCNT_W-1:0] RCNT_END  = WCNT_W'(NUM_IN);
   localparam logic [DCNT_W-1:0] DCNT_END  = DCNT_W'(NUM_NEURON);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

   state_e                state_q;
   logic [WCNT_W-1:0]     wcnt_q, rcnt_q;
   logic [DCNT_W-1:0]     dcnt_q;
   logic [TCNT_W-1:0]     tcnt_q;
   logic [NUM_NEURON-1:0] seen_q, seen_d, capture;
   logic                  in_ready_q, nrn_in_valid_q, out_valid_q, busy_q, err_q;
   logic                  in_hs, load_last, bcast_fetch, out_hs, drain_fetch;
   logic                  wait_done, wait_tmo, spurious;

   always_comb begin
      in_hs       = (state_q == S_LOAD) && in_valid && in_ready_q;
      load_last   = in_hs && (wcnt_q == WCNT_LAST);
      bcast_fetch = (state_q == S_BCAST) && (rcnt_q != RCNT_END);
      out_hs      = out_valid_q && out_ready;
      drain_fetch = (state_q == S_DRAIN) && out_hs && (dcnt_q != DCNT_END);
      capture     = (state_q == S_WAIT) ? (nrn_out_valid & ~seen_q) : '0;
      seen_d      = seen_q | capture;
      wait_done   = (state_q == S_WAIT) && (&seen_d);
      wait_tmo    = (state_q == S_WAIT) && !(&seen_d) && (tcnt_q == TCNT_LAST);
      spurious    = (state_q == S_WAIT) ? |(nrn_out_valid & seen_q) : |nrn_out_valid;
   end

   // rcnt/dcnt index the next word to fetch; the read register presents the previous one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         wcnt_q         <= '0;
         rcnt_q         <= '0;
         dcnt_q         <= '0;
         tcnt_q         <= '0;
         seen_q         <= '0;
         in_ready_q     <= 1'b0;
         nrn_in_valid_q <= 1'b0;
         out_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         if (spurious || wait_tmo)
            err_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               state_q    <= S_LOAD;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b1;
            end
            S_LOAD: begin
               if (load_last) begin
                  wcnt_q         <= '0;
                  rcnt_q         <= WCNT_W'(1);
                  in_ready_q     <= 1'b0;
                  nrn_in_valid_q <= 1'b1;
                  state_q        <= S_BCAST;
               end else if (in_hs) begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            S_BCAST: begin
               if (rcnt_q == RCNT_END) begin
                  rcnt_q         <= '0;
                  nrn_in_valid_q <= 1'b0;
                  state_q        <= S_WAIT;
               end else begin
                  rcnt_q <= rcnt_q + 1'b1;
               end
            end
            S_WAIT: begin
               if (wait_done || wait_tmo) begin
                  seen_q      <= '0;
                  tcnt_q      <= '0;
                  dcnt_q      <= DCNT_W'(1);
                  out_valid_q <= 1'b1;
                  state_q     <= S_DRAIN;
               end else begin
                  seen_q <= seen_d;
                  if (tcnt_q != TCNT_MAX)
                     tcnt_q <= tcnt_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (out_hs && dcnt_q == DCNT_END) begin
                  dcnt_q      <= '0;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end else if (out_hs) begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   seq_buf #(.DEPTH(NUM_IN), .WIDTH(DATA_W)) u_in_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (in_hs),
      .wr_addr_i  (wcnt_q[IN_AW-1:0]),
      .wr_data_i  (in_data),
      .par_we_i   ('0),
      .par_data_i ('0),
      .rd_en_i    (load_last || bcast_fetch),
      .rd_addr_i  (rcnt_q[IN_AW-1:0]),
      .rd_data_o  (nrn_in_data)
   );

   seq_buf #(.DEPTH(NUM_NEURON), .WIDTH(OUT_W)) u_out_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (1'b0),
      .wr_addr_i  ('0),
      .wr_data_i  ('0),
      .par_we_i   (capture),
      .par_data_i (nrn_out_data),
      .rd_en_i    (wait_done || wait_tmo || drain_fetch),
      .rd_addr_i  (dcnt_q[NN_AW-1:0]),
      .rd_data_o  (out_data)
   );

   assign in_ready     = in_ready_q;
   assign nrn_in_valid = nrn_in_valid_q;
   assign out_valid    = out_valid_q;
   assign busy         = busy_q;
   assign err          = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised scoreboard bench for layer_sequencer with behavioural neuron models.
module tb_layer_sequencer;

   localparam int NUM_IN     = 4;
   localparam int NUM_NEURON = 3;
   localparam int DATA_W     = 16;
   localparam int OUT_W      = 16;
   localparam int TIMEOUT    = 8;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        in_valid = 1'b0;
   logic                        in_ready;
   logic [DATA_W-1:0]           in_data = '0;
   logic                        nrn_in_valid;
   logic [DATA_W-1:0]           nrn_in_data;
   logic [NUM_NEURON-1:0]       nrn_out_valid;
   logic [NUM_NEURON-1:0]       nrn_ov_nrn = '0;
   logic [NUM_NEURON-1:0]       spur_ov = '0;
   logic [NUM_NEURON*OUT_W-1:0] nrn_out_data = '0;
   logic                        out_valid;
   logic                        out_ready = 1'b0;
   logic [OUT_W-1:0]            out_data;
   logic                        busy;
   logic                        err;

   assign nrn_out_valid = nrn_ov_nrn | spur_ov;

   always #5 clk = ~clk;

   layer_sequencer #(
      .NUM_IN(NUM_IN), .NUM_NEURON(NUM_NEURON), .DATA_W(DATA_W),
      .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .nrn_in_valid(nrn_in_valid), .nrn_in_data(nrn_in_data),
      .nrn_out_valid(nrn_out_valid), .nrn_out_data(nrn_out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err(err)
   );

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] exp_bcast[$];
   logic [OUT_W-1:0]  exp_out[$];

   // Reference model state: input vector, per-neuron schedule, last captured result
   logic [DATA_W-1:0] wv [NUM_IN];
   int                sched_delay [NUM_NEURON];
   logic [OUT_W-1:0]  sched_val [NUM_NEURON];
   logic [OUT_W-1:0]  model_buf [NUM_NEURON];
   int                dup_delay = -1;
   logic [OUT_W-1:0]  dup_val = '0;
   bit                tmo_exp = 1'b0;
   bit                err_exp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a word
   int               blen = 0;
   bit               prev_nv = 1'b0;
   bit               stalled = 1'b0;
   logic [OUT_W-1:0] held = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         blen = 0;
         prev_nv = 1'b0;
         stalled = 1'b0;
      end else begin
         if (nrn_in_valid) begin
            blen++;
            if (exp_bcast.size() == 0) fail_now("bcast_unexpected");
            else check("bcast_data", nrn_in_data, exp_bcast.pop_front());
         end else if (prev_nv) begin
            check("burst_len", blen, NUM_IN);
            blen = 0;
         end
         prev_nv = nrn_in_valid;
         if (stalled) check("out_hold", out_data, held);
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) fail_now("out_unexpected");
            else check("out_data", out_data, exp_out.pop_front());
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
      end
   end

   // Neuron models: after NUM_IN broadcast words, pulse per the schedule
   task automatic run_wait();
      int last = -1;
      logic [NUM_NEURON-1:0] ov;
      for (int k = 0; k < NUM_NEURON; k++)
         if (sched_delay[k] > last) last = sched_delay[k];
      if (tmo_exp) last = TIMEOUT - 1;
      for (int c = 0; c <= last; c++) begin
         @(posedge clk); #1;
         ov = '0;
         for (int k = 0; k < NUM_NEURON; k++)
            if (sched_delay[k] == c) begin
               ov[k] = 1'b1;
               nrn_out_data[k*OUT_W +: OUT_W] = sched_val[k];
            end
         if (dup_delay == c) begin
            ov[0] = 1'b1;
            nrn_out_data[0 +: OUT_W] = dup_val;
         end
         nrn_ov_nrn = ov;
         @(negedge clk);
         if (tmo_exp) check("err_before_timeout", err, 0);
      end
      @(posedge clk); #1;
      nrn_ov_nrn = '0;
      @(negedge clk);
      check("drain_start", out_valid, 1);
      if (tmo_exp) check("err_at_timeout", err, 1);
   endtask

   initial begin : neuron_model
      int bcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) bcnt = 0;
         else if (nrn_in_valid) begin
            bcnt++;
            if (bcnt == NUM_IN) begin
               bcnt = 0;
               run_wait();
            end
         end
      end
   end

   task automatic load_vector(input bit toggle, input bit spur);
      int i = 0;
      int guard = 0;
      bit v;
      for (int n = 0; n < NUM_IN; n++) exp_bcast.push_back(wv[n]);
      while (i < NUM_IN && guard < 200) begin
         v        = toggle ? (guard % 2 == 0) : 1'b1;
         in_valid = v;
         in_data  = v ? wv[i] : DATA_W'($urandom);
         spur_ov  = (spur && guard == 2) ? NUM_NEURON'(1) : '0;
         @(negedge clk);
         if (v && in_ready) i++;
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      spur_ov  = '0;
      if (i < NUM_IN) fail_now("load_timeout");
   endtask

   task automatic drain_vector(input bit rand_ready, input bit stall);
      int acc = 0;
      int guard = 0;
      int stall_left = stall ? 3 : 0;
      while (acc < NUM_NEURON && guard < 400) begin
         if (stall_left > 0 && acc == 1) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(negedge clk);
         if (out_valid && out_ready) acc++;
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      if (acc < NUM_NEURON) fail_now("drain_timeout");
      check("busy_after_drain", busy, 0);
      check("out_valid_after_drain", out_valid, 0);
      check("out_queue_empty", exp_out.size(), 0);
      check("err_flag", err, err_exp);
   endtask

   task automatic run_vector(input bit toggle, input bit rand_ready, input bit stall, input bit spur);
      load_vector(toggle, spur);
      if (spur) check("err_after_load_spur", err, 1);
      for (int k = 0; k < NUM_NEURON; k++) begin
         if (sched_delay[k] >= 0 && sched_delay[k] < TIMEOUT) model_buf[k] = sched_val[k];
         exp_out.push_back(model_buf[k]);
      end
      drain_vector(rand_ready, stall);
   endtask

   task automatic randomise_vector(input int max_delay);
      for (int n = 0; n < NUM_IN; n++) wv[n] = DATA_W'($urandom);
      for (int k = 0; k < NUM_NEURON; k++) begin
         sched_delay[k] = $urandom_range(0, max_delay);
         sched_val[k]   = OUT_W'($urandom);
      end
      dup_delay = -1;
      tmo_exp   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_nrn_in_valid"}, nrn_in_valid, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_nrn_in_data"}, nrn_in_data, 0);
      check({tag, "_out_data"}, out_data, 0);
   endtask

   task automatic apply_reset();
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      exp_bcast.delete();
      exp_out.delete();
      err_exp = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin : stimulus
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Nominal vector 1,2,3,4 with results 0xA,0xB,0xC
      for (int n = 0; n < NUM_IN; n++) wv[n] = DATA_W'(n + 1);
      sched_delay = '{2, 3, 4};
      sched_val   = '{16'h000A, 16'h000B, 16'h000C};
      run_vector(1'b0, 1'b0, 1'b0, 1'b0);

      // Backpressure on both sides
      randomise_vector(5);
      run_vector(1'b1, 1'b0, 1'b1, 1'b0);

      // All neurons pulse together
      randomise_vector(5);
      sched_delay = '{2, 2, 2};
      run_vector(1'b0, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         randomise_vector(6);
         run_vector(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      end

      // Neuron 2 never answers; its entry keeps the previous result
      randomise_vector(5);
      sched_delay[2] = -1;
      tmo_exp = 1'b1;
      err_exp = 1'b1;
      run_vector(1'b0, 1'b1, 1'b0, 1'b0);
      tmo_exp = 1'b0;

      // Spurious pulse during LOAD
      apply_reset();
      randomise_vector(5);
      err_exp = 1'b1;
      run_vector(1'b0, 1'b0, 1'b0, 1'b1);

      // Duplicate pulse for an already-captured neuron in WAIT
      apply_reset();
      randomise_vector(5);
      sched_delay = '{1, 4, 5};
      dup_delay   = 3;
      dup_val     = ~sched_val[0];
      check("err_clear_before_dup", err, 0);
      err_exp = 1'b1;
      run_vector(1'b0, 1'b0, 1'b0, 1'b0);
      dup_delay = -1;

      // Asynchronous reset in the middle of the broadcast burst
      apply_reset();
      randomise_vector(5);
      load_vector(1'b0, 1'b0);
      @(posedge clk); #2;
      check("bcast_active_pre_reset", nrn_in_valid, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midburst");
      exp_bcast.delete();
      exp_out.delete();
      err_exp = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      randomise_vector(5);
      run_vector(1'b1, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
